div_unit: RTL and testbench



---
 rtl/div_unit_pkg.sv | 22 ++
 rtl/div_unit_if.sv | 24 ++
 rtl/div_unit.sv | 118 +++++++++++
 tb/tb_div_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared constants for the multi-cycle divider: FSM state encoding, handshake levels
// and the execute-stage aluop codes that select DIV/DIVU.
package div_unit_pkg;

  localparam int unsigned DivDataWidth = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'd0,
    DivByZero = 2'd1,
    DivOn     = 2'd2,
    DivEnd    = 2'd3
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] ExeDivOp  = 8'b0001_1010;
  localparam logic [7:0] ExeDivuOp = 8'b0001_1011;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the execute stage (master) and the divider (slave).
interface div_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    start_in;
  logic                    annul_in;
  logic                    signed_in;
  logic [DATA_WIDTH-1:0]   op1_in;
  logic [DATA_WIDTH-1:0]   op2_in;
  logic [2*DATA_WIDTH-1:0] result_out;
  logic                    ready_out;

  modport master (
    output start_in, annul_in, signed_in, op1_in, op2_in,
    input  result_out, ready_out
  );

  modport slave (
    input  start_in, annul_in, signed_in, op1_in, op2_in,
    output result_out, ready_out
  );

endinterface

// File: rtl/div_unit.sv
// Restoring divider: one quotient bit per clock, signs stripped on entry and restored on exit.
// result_out = {remainder, quotient}, valid while ready_out is high.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DivDataWidth
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);

  localparam int unsigned W        = DATA_WIDTH;
  localparam logic [5:0]  LastStep = 6'(DATA_WIDTH);

  div_state_e         state_q;
  logic [5:0]         cnt_q;
  logic [W-1:0]       quo_q;
  logic [W-1:0]       rem_q;
  logic [W-1:0]       dsor_q;
  logic               sign1_q;
  logic               sign2_q;
  logic               signed_q;
  logic [2*W-1:0]     result_q;
  logic               ready_q;

  logic [W-1:0]       rem_shift;
  logic [W-1:0]       rem_diff;
  logic [W-1:0]       rem_step;
  logic [W-1:0]       quo_step;
  logic [W-1:0]       quo_fix;
  logic [W-1:0]       rem_fix;
  logic               take;

  function automatic logic [W-1:0] mag(logic [W-1:0] x, logic is_signed);
    return (is_signed && x[W-1]) ? -x : x;
  endfunction

  // A set top bit of rem_q means the shifted value exceeds W bits and so always beats the
  // divisor; the W-bit wrap-around subtraction still yields the exact remainder.
  always_comb begin
    rem_shift = {rem_q[W-2:0], quo_q[W-1]};
    rem_diff  = rem_shift - dsor_q;
    take      = rem_q[W-1] | (rem_shift >= dsor_q);
    rem_step  = take ? rem_diff : rem_shift;
    quo_step  = {quo_q[W-2:0], take};
    quo_fix   = (signed_q && (sign1_q ^ sign2_q)) ? -quo_q : quo_q;
    rem_fix   = (signed_q && sign1_q) ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dsor_q   <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      signed_q <= 1'b0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      unique case (state_q)
        DivFree: begin
          if (bus.start_in == DivStart && !bus.annul_in) begin
            if (bus.op2_in == '0) begin
              state_q <= DivByZero;
            end else begin
              state_q  <= DivOn;
              cnt_q    <= '0;
              quo_q    <= mag(bus.op1_in, bus.signed_in);
              dsor_q   <= mag(bus.op2_in, bus.signed_in);
              rem_q    <= '0;
              sign1_q  <= bus.op1_in[W-1];
              sign2_q  <= bus.op2_in[W-1];
              signed_q <= bus.signed_in;
            end
          end
        end
        DivByZero: begin
          if (bus.annul_in) begin
            state_q <= DivFree;
          end else begin
            state_q  <= DivEnd;
            result_q <= '0;
            ready_q  <= DivResultReady;
          end
        end
        DivOn: begin
          if (bus.annul_in) begin
            state_q <= DivFree;
          end else if (cnt_q == LastStep) begin
            state_q  <= DivEnd;
            result_q <= {rem_fix, quo_fix};
            ready_q  <= DivResultReady;
          end else begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + 6'd1;
          end
        end
        DivEnd: begin
          if (bus.start_in == DivStop) begin
            state_q  <= DivFree;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
          end
        end
        default: state_q <= DivFree;
      endcase
    end
  end

  assign bus.result_out = result_q;
  assign bus.ready_out  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomised bench for div_unit against an arithmetic reference with a latency model.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_if #(.DATA_WIDTH(32)) dif ();

  div_unit #(.DATA_WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  logic chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic (truncating division, remainder takes dividend sign).
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Latency model: a request accepted at edge E yields a result after E+1 (zero divisor)
  // or E+33, held while start stays high.
  logic        m_busy;
  logic        m_ready;
  int          m_left;
  logic [63:0] m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
      m_left  <= 0;
      m_res   <= 64'd0;
    end else if (m_ready) begin
      if (!dif.start_in) m_ready <= 1'b0;
    end else if (m_busy) begin
      if (dif.annul_in) begin
        m_busy <= 1'b0;
      end else if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (dif.start_in && !dif.annul_in) begin
      m_busy <= 1'b1;
      m_left <= (dif.op2_in == 32'd0) ? 1 : 33;
      m_res  <= ref_div(dif.op1_in, dif.op2_in, dif.signed_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ready", {63'd0, dif.ready_out}, {63'd0, m_ready});
      check("cyc_result", dif.result_out, m_ready ? m_res : 64'd0);
    end
  end

  // Called at #1 after a clock edge; returns at #1 after the edge that drops start.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, input logic scramble,
                         input logic use_lit, input logic [63:0] lit);
    int   n;
    logic seen;
    dif.op1_in    = a;
    dif.op2_in    = b;
    dif.signed_in = s;
    dif.start_in  = DivStart;
    @(posedge clk);
    #1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (scramble && n == 5) begin
        dif.op1_in = $urandom;
        dif.op2_in = $urandom;
      end
      seen = dif.ready_out;
    end
    check("latency", 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
    if (use_lit) check("result_lit", dif.result_out, lit);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      check("hold_ready", {63'd0, dif.ready_out}, 64'd1);
    end
    dif.start_in = DivStop;
    @(posedge clk);
    #1;
    check("drop_ready", {63'd0, dif.ready_out}, 64'd0);
    check("drop_result", dif.result_out, 64'd0);
  endtask

  task automatic idle_no_ready(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (dif.ready_out) seen = 1'b1;
    end
    check(name, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          n;
    logic        seen;

    dif.start_in  = DivStop;
    dif.annul_in  = 1'b0;
    dif.signed_in = 1'b0;
    dif.op1_in    = 32'd0;
    dif.op2_in    = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {63'd0, dif.ready_out}, 64'd0);
    check("reset_result", dif.result_out, 64'd0);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    check("model_100_7", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
    check("model_m7_2", ref_div(32'hFFFFFFF9, 32'd2, 1'b1), 64'hFFFFFFFF_FFFFFFFD);
    check("model_ovf", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), 64'h00000000_80000000);
    check("model_div0", ref_div(32'd1234, 32'd0, 1'b1), 64'd0);

    run_div(32'd100, 32'd7, 1'b0, 0, 1'b0, 1'b1, 64'h00000002_0000000E);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 2, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFD);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 1'b0, 1'b1, 64'h00000000_80000000);
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, 1, 1'b1, 1'b1, 64'h00000000_FFFFFFFF);
    run_div(32'd1234, 32'd0, 1'b1, 3, 1'b0, 1'b1, 64'd0);
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, 0, 1'b1, 1'b1, 64'h00000001_FFFFFFFD);

    // Annul at iteration 10 discards the division
    dif.op1_in    = 32'd1000;
    dif.op2_in    = 32'd3;
    dif.signed_in = 1'b0;
    dif.start_in  = DivStart;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    dif.annul_in = 1'b1;
    @(posedge clk);
    #1;
    dif.annul_in = 1'b0;
    dif.start_in = DivStop;
    idle_no_ready("annul_no_ready", 40);
    run_div(32'd50, 32'd5, 1'b0, 0, 1'b0, 1'b1, 64'h00000000_0000000A);

    // start with annul in FREE never starts a division
    dif.op1_in   = 32'd9;
    dif.op2_in   = 32'd3;
    dif.start_in = DivStart;
    dif.annul_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    dif.start_in = DivStop;
    dif.annul_in = 1'b0;
    idle_no_ready("start_annul_no_ready", 40);

    // Asynchronous reset mid-ON
    dif.op1_in   = 32'd12345;
    dif.op2_in   = 32'd17;
    dif.start_in = DivStart;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #2;
    rst          = 1'b1;
    dif.start_in = DivStop;
    #1;
    check("rst_on_ready", {63'd0, dif.ready_out}, 64'd0);
    check("rst_on_result", dif.result_out, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_no_ready("rst_on_no_ready", 40);

    // Asynchronous reset while a result is held in END
    dif.op1_in   = 32'd777;
    dif.op2_in   = 32'd5;
    dif.start_in = DivStart;
    @(posedge clk);
    #1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      seen = dif.ready_out;
    end
    check("end_result", dif.result_out, 64'h00000002_0000009B);
    #1;
    rst          = 1'b1;
    dif.start_in = DivStop;
    #1;
    check("rst_end_ready", {63'd0, dif.ready_out}, 64'd0);
    check("rst_end_result", dif.result_out, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_div(32'd50, 32'd5, 1'b0, 0, 1'b0, 1'b1, 64'h00000000_0000000A);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (b == 32'd0 && $urandom_range(0, 1) == 1) b = 32'd3;
      s = 1'($urandom_range(0, 1));
      run_div(a, b, s, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 64'd0);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
